// File: rtl/cache_mem_arbiter.sv
// Arbitrates I-cache and D-cache line transfers onto one burst memory port.
// Define ARB_DCACHE_PRIORITY_EN to give the D side fixed priority on ties.
module cache_mem_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int BURST_LEN  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic                  i_done,
  input  logic                  d_req,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic                  d_we,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_wready,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic                  d_done,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic                  mem_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int BEAT_BITS   = $clog2(BURST_LEN);
  localparam int OFFSET_BITS = $clog2(BURST_LEN * DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    ~((ADDR_WIDTH'(1) << OFFSET_BITS) - ADDR_WIDTH'(1));
  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, ADDR, BURST, DONE} state_t;

  state_t                  state_reg, state_next;
  logic                    win_d_reg, win_d_next;
  logic                    we_reg, we_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [BEAT_BITS-1:0]    beat_reg, beat_next;
  logic                    last_d_reg, last_d_next;
  logic                    pick_d;

`ifdef ARB_DCACHE_PRIORITY_EN
  assign pick_d = d_req;
`else
  // On a tie the side that did not finish the previous transfer wins.
  assign pick_d = d_req && (!i_req || !last_d_reg);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      win_d_reg  <= 1'b0;
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      beat_reg   <= '0;
      last_d_reg <= 1'b1;
    end else begin
      state_reg  <= state_next;
      win_d_reg  <= win_d_next;
      we_reg     <= we_next;
      addr_reg   <= addr_next;
      beat_reg   <= beat_next;
      last_d_reg <= last_d_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    win_d_next  = win_d_reg;
    we_next     = we_reg;
    addr_next   = addr_reg;
    beat_next   = beat_reg;
    last_d_next = last_d_reg;
    case (state_reg)
      IDLE: begin
        if (i_req || d_req) begin
          state_next = ADDR;
          win_d_next = pick_d;
          we_next    = pick_d && d_we;
          addr_next  = (pick_d ? d_addr : i_addr) & LINE_MASK;
        end
      end
      ADDR: begin
        if (mem_ack) begin
          state_next = BURST;
          beat_next  = '0;
        end
      end
      BURST: begin
        if (mem_valid) begin
          beat_next = beat_reg + BEAT_BITS'(1);
          if (beat_reg == LAST_BEAT) state_next = DONE;
        end
      end
      DONE: begin
        state_next  = IDLE;
        last_d_next = win_d_reg;
      end
      default: state_next = IDLE;
    endcase
  end

  logic active, in_burst, rd_beat;
  assign active   = (state_reg != IDLE);
  assign in_burst = (state_reg == BURST);
  assign rd_beat  = in_burst && !we_reg && mem_valid;

  // Data paths are gated by state so every output is zero while idle or in reset.
  assign i_gnt     = active && !win_d_reg;
  assign d_gnt     = active && win_d_reg;
  assign mem_req   = (state_reg == ADDR);
  assign mem_addr  = active ? addr_reg : '0;
  assign mem_we    = active && we_reg;
  assign i_rvalid  = rd_beat && !win_d_reg;
  assign d_rvalid  = rd_beat && win_d_reg;
  assign d_wready  = in_burst && we_reg && mem_valid;
  assign rdata     = (in_burst && !we_reg) ? mem_rdata : '0;
  assign mem_wdata = (in_burst && we_reg) ? d_wdata : '0;
  assign i_done    = (state_reg == DONE) && !win_d_reg;
  assign d_done    = (state_reg == DONE) && win_d_reg;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios plus randomized
// transfers checked against a transaction-level arbitration/burst model.
module tb_cache_mem_arbiter;

  localparam int LINE_BYTES = 8 * 64 / 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we, mem_ack, mem_valid;
  logic [63:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic        i_gnt, i_rvalid, i_done, d_wready, d_gnt, d_rvalid, d_done;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata, rdata;

  int n_checks = 0;
  int n_errors = 0;
  bit m_last_d;

  cache_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_done(i_done),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata), .d_wready(d_wready),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_done(d_done),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_valid(mem_valid), .mem_rdata(mem_rdata), .rdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Order: mem_req, i_rvalid, d_rvalid, d_wready, i_done, d_done, i_gnt, d_gnt
  task automatic chk_ctrl(input string tag, input logic [7:0] exp);
    chk(tag, 64'({mem_req, i_rvalid, d_rvalid, d_wready, i_done, d_done, i_gnt, d_gnt}),
        64'(exp));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctrl"}, 64'({i_gnt, i_rvalid, i_done, d_wready, d_gnt, d_rvalid, d_done,
                            mem_req, mem_we}), 64'd0);
    chk({tag, "_mem_addr"}, mem_addr, 64'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 64'd0);
    chk({tag, "_rdata"}, rdata, 64'd0);
  endtask

  function automatic logic [63:0] line_of(input logic [63:0] a);
    return (a / LINE_BYTES) * LINE_BYTES;
  endfunction

  // Called with requests already driven while the DUT is idle; returns one
  // cycle after DONE, inside the following idle cycle.
  task automatic run_xfer(input int ack_dly, input int gap_min, input int gap_max,
                          input bit seq_data, input bit hold, input bit raise_d);
    bit wd, wwe, gi, gd;
    int gap;
    logic [63:0] eaddr, dat;
`ifdef ARB_DCACHE_PRIORITY_EN
    wd = d_req;
`else
    wd = (i_req && d_req) ? !m_last_d : d_req;
`endif
    eaddr = line_of(wd ? d_addr : i_addr);
    wwe   = wd ? d_we : 1'b0;
    gi    = !wd;
    gd    = wd;
    $display("xfer: winner=%s addr=0x%0h we=%0d", wd ? "D" : "I", eaddr, wwe);
    @(negedge clk);
    if (!hold) begin
      if (wd) d_req = 1'b0; else i_req = 1'b0;
    end
    for (int k = 0; k <= ack_dly; k++) begin
      mem_ack   = (k == ack_dly);
      mem_valid = (k < ack_dly) ? 1'($urandom_range(1, 0)) : 1'b0;
      mem_rdata = {$urandom, $urandom};
      #1;
      chk_ctrl("addr_phase", {1'b1, 5'b0, gi, gd});
      chk("mem_addr", mem_addr, eaddr);
      chk("mem_we", 64'(mem_we), 64'(wwe));
      @(negedge clk);
    end
    for (int b = 0; b < 8; b++) begin
      gap = $urandom_range(gap_max, gap_min);
      for (int g = 0; g < gap; g++) begin
        mem_valid = 1'b0;
        mem_ack   = 1'($urandom_range(1, 0));
        #1 chk_ctrl("burst_stall", {6'b0, gi, gd});
        @(negedge clk);
      end
      dat       = seq_data ? 64'hA0 + 64'(b) : {$urandom, $urandom};
      mem_valid = 1'b1;
      mem_ack   = 1'($urandom_range(1, 0));
      mem_rdata = dat;
      d_wdata   = ~dat;
      #1;
      chk_ctrl("burst_beat", {1'b0, !wwe && gi, !wwe && gd, wwe, 2'b0, gi, gd});
      if (wwe) chk("mem_wdata", mem_wdata, ~dat);
      else     chk("rdata", rdata, dat);
      @(negedge clk);
    end
    mem_valid = 1'b0;
    mem_ack   = 1'b0;
    #1 chk_ctrl("done", {4'b0, gi, gd, gi, gd});
    m_last_d = wd;
    if (raise_d) d_req = 1'b1;
    @(negedge clk);
    #1 chk_ctrl("idle_after", 8'h00);
  endtask

  task automatic reset_pulse();
    #1 reset = 1'b1;
    #1 chk_zero("reset_pulse");
    @(negedge clk);
    reset    = 1'b0;
    m_last_d = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    i_req     = 1'b0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    i_addr    = '0;
    d_addr    = '0;
    d_wdata   = 64'h1234_5678;
    mem_rdata = 64'hDEAD_BEEF;
    mem_valid = 1'b1;
    mem_ack   = 1'b1;
    #1 chk_zero("reset_state");
    @(negedge clk);
    mem_valid = 1'b0;
    mem_ack   = 1'b0;
    reset     = 1'b0;
    m_last_d  = 1'b1;
    @(negedge clk);
    #1 chk_ctrl("idle_no_req", 8'h00);

    // Single I fill, ack after two cycles, beats 0xA0..0xA7.
    i_addr = 64'h1234;
    i_req  = 1'b1;
    run_xfer(2, 0, 0, 1'b1, 1'b0, 1'b0);

    // D writeback with one stall cycle ahead of every beat.
    d_addr = 64'h4048;
    d_we   = 1'b1;
    d_req  = 1'b1;
    run_xfer(1, 1, 1, 1'b0, 1'b0, 1'b0);

    // D request raised during the I transfer's DONE cycle.
    i_addr = {$urandom, $urandom};
    d_addr = {$urandom, $urandom};
    d_we   = 1'b0;
    i_req  = 1'b1;
    run_xfer(0, 0, 1, 1'b0, 1'b0, 1'b1);
    run_xfer(1, 0, 1, 1'b0, 1'b0, 1'b0);

    // Leave last-granted at I so the reset value is what decides the next tie.
    i_req = 1'b1;
    run_xfer(0, 0, 0, 1'b0, 1'b0, 1'b0);
    reset_pulse();

    // Simultaneous held requests after reset.
    i_addr = {$urandom, $urandom};
    d_addr = {$urandom, $urandom};
    d_we   = 1'b1;
    i_req  = 1'b1;
    d_req  = 1'b1;
    for (int t = 0; t < 3; t++) run_xfer($urandom_range(2, 0), 0, 1, 1'b0, 1'b1, 1'b0);
    i_req = 1'b0;
    d_req = 1'b0;

    // Reset asserted mid-read after the third beat.
    @(negedge clk);
    i_addr = {$urandom, $urandom};
    i_req  = 1'b1;
    @(negedge clk);
    i_req   = 1'b0;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    for (int b = 0; b < 3; b++) begin
      mem_valid = 1'b1;
      mem_rdata = {$urandom, $urandom};
      @(negedge clk);
    end
    mem_valid = 1'b1;
    mem_rdata = {$urandom, $urandom} | 64'h1;
    d_wdata   = {$urandom, $urandom} | 64'h1;
    #1 chk("pre_reset_rvalid", 64'(i_rvalid), 64'd1);
    #1 reset = 1'b1;
    #1 chk_zero("mid_burst_reset");
    mem_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1 chk("reset_no_done", 64'({i_done, i_gnt, mem_req}), 64'd0);
    end
    reset    = 1'b0;
    m_last_d = 1'b1;
    i_addr   = {$urandom, $urandom};
    i_req    = 1'b1;
    run_xfer(1, 0, 1, 1'b0, 1'b0, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 12; n++) begin
      logic [1:0] r;
      r      = 2'($urandom_range(3, 1));
      i_req  = r[0];
      d_req  = r[1];
      i_addr = {$urandom, $urandom};
      d_addr = {$urandom, $urandom};
      d_we   = 1'($urandom_range(1, 0));
      run_xfer($urandom_range(3, 0), 0, 2, 1'b0, 1'($urandom_range(1, 0)), 1'b0);
    end
    i_req = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    #1 chk_ctrl("final_idle", 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
